// File: rtl/psum_rx_pkg.sv
// Shared widths, defaults and the remote-fetch state encoding for psum_rx.
package psum_rx_pkg;
  localparam int BW_PSUM_DEF = 20;
  localparam int SW          = BW_PSUM_DEF + 4;
  localparam int ROWS_DEF    = 8;

  typedef enum logic [1:0] {R_IDLE, R_POP, R_CAP, R_FULL} rstate_t;
endpackage

// File: rtl/psum_rx_if.sv
// FIFO read side, local core sum port and combined-sum output handshake.
interface psum_rx_if
  import psum_rx_pkg::*;
#(parameter int W = SW) ();
  logic         fifo_empty;
  logic         fifo_rd;
  logic [W-1:0] fifo_data;
  logic         local_vld;
  logic [W-1:0] local_sum;
  logic         local_busy;
  logic         sum_vld;
  logic [W-1:0] sum_out;
  logic         sum_rdy;

  modport slave (
    input  fifo_empty, fifo_data, local_vld, local_sum, sum_rdy,
    output fifo_rd, local_busy, sum_vld, sum_out
  );
  modport master (
    output fifo_empty, fifo_data, local_vld, local_sum, sum_rdy,
    input  fifo_rd, local_busy, sum_vld, sum_out
  );
endinterface

// File: rtl/psum_sat_add.sv
// Signed saturating adder: one guard bit, clamp to the W-bit signed range.
module psum_sat_add
  import psum_rx_pkg::*;
#(parameter int W = SW) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);
  logic [W:0] s;

  assign s   = {a[W-1], a} + {b[W-1], b};
  // guard bit disagreeing with the sign bit means the W-bit result wrapped
  assign ovf = s[W] ^ s[W-1];
  assign y   = !ovf  ? s[W-1:0] :
               s[W]  ? {1'b1, {(W-1){1'b0}}} :
                       {1'b0, {(W-1){1'b1}}};
endmodule

// File: rtl/psum_rx.sv
// Pairs a remote psum (popped from the async FIFO) with the local core sum,
// emits the saturated combined sum and tracks ROWS sums per pass.
module psum_rx
  import psum_rx_pkg::*;
#(
  parameter int BW_PSUM = BW_PSUM_DEF,
  parameter int ROWS    = ROWS_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clr,
  psum_rx_if.slave bus,
  output logic     pass_done,
  output logic     ovf,
  output logic     err
);
  localparam int W  = BW_PSUM + 4;
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [1:0]    rsync;
  logic          rst_n;
  rstate_t       state, nxt;
  logic [W-1:0]  rem_q, loc_q, out_q, sat_y;
  logic          loc_full, out_vld, sat_ovf, fire, xfer;
  logic [CW-1:0] cnt;

  // assert asynchronously, release two clocks after reset goes high
  always_ff @(posedge clk or negedge reset)
    if (!reset) rsync <= 2'b00;
    else        rsync <= {rsync[0], 1'b1};
  assign rst_n = rsync[1];

  assign fire = loc_full && (state == R_FULL) && (!out_vld || bus.sum_rdy);
  assign xfer = out_vld && bus.sum_rdy;

  psum_sat_add #(.W(W)) u_sat (.a(loc_q), .b(rem_q), .y(sat_y), .ovf(sat_ovf));

  // remote fetch state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= R_IDLE;
    else        state <= nxt;

  // remote fetch next state; a pop is one cycle, data lands the cycle after
  always_comb begin
    nxt = state;
    if (clr) nxt = R_IDLE;
    else begin
      case (state)
        R_IDLE:  if (!bus.fifo_empty && !pass_done) nxt = R_POP;
        R_POP:   nxt = R_CAP;
        R_CAP:   nxt = R_FULL;
        R_FULL:  if (fire) nxt = R_IDLE;
        default: nxt = R_IDLE;
      endcase
    end
  end

  assign bus.fifo_rd    = (state == R_POP);
  assign bus.local_busy = loc_full;
  assign bus.sum_vld    = out_vld;
  assign bus.sum_out    = out_q;

  // remote slot capture; a word popped before clr is simply never captured
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                       rem_q <= '0;
    else if (state == R_CAP && !clr)  rem_q <= bus.fifo_data;

  // local slot; a word arriving while occupied is dropped and flagged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      loc_full <= 1'b0;
      loc_q    <= '0;
      err      <= 1'b0;
    end else if (clr) begin
      loc_full <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (fire) loc_full <= 1'b0;
      else if (bus.local_vld && !loc_full) begin
        loc_full <= 1'b1;
        loc_q    <= bus.local_sum;
      end
      if (bus.local_vld && loc_full) err <= 1'b1;
    end

  // output register: refill in the drain cycle keeps one sum per cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_q   <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      out_vld <= 1'b0;
      out_q   <= '0;
      ovf     <= 1'b0;
    end else if (fire) begin
      out_vld <= 1'b1;
      out_q   <= sat_y;
      if (sat_ovf) ovf <= 1'b1;
    end else if (bus.sum_rdy) begin
      out_vld <= 1'b0;
    end

  // row counter and sticky end-of-pass flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      pass_done <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      pass_done <= 1'b0;
    end else if (xfer) begin
      if (cnt == CW'(ROWS - 1)) begin
        cnt       <= '0;
        pass_done <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_psum_rx.sv
// Scoreboard bench for psum_rx: FIFO model, local driver, output monitor.
module tb_psum_rx;
  logic clk = 0;
  logic reset, clr;
  logic pass_done, ovf, err;

  psum_rx_if bus ();

  psum_rx #(.BW_PSUM(20), .ROWS(8)) dut (
    .clk(clk), .reset(reset), .clr(clr), .bus(bus),
    .pass_done(pass_done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int xfers = 0, rd_cnt = 0;
  int mem [0:255];
  int wp = 0, rp = 0;
  logic [23:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] sat24(input int a, input int b);
    longint s;
    s = longint'(a) + longint'(b);
    if (s > 64'sd8388607) s = 64'sd8388607;
    else if (s < -64'sd8388608) s = -64'sd8388608;
    return s[23:0];
  endfunction

  // async FIFO read side model: data valid the cycle after the pop strobe
  assign bus.fifo_empty = (wp == rp);
  always @(posedge clk)
    if (bus.fifo_rd) begin
      rd_cnt        <= rd_cnt + 1;
      bus.fifo_data <= 24'(mem[rp[7:0]]);
      rp            <= rp + 1;
    end

  // output monitor: every transfer is checked against the scoreboard
  always @(negedge clk)
    if (bus.sum_vld && bus.sum_rdy) begin
      xfers++;
      if (exp_q.size() == 0) chk("sum_extra", exp_q.size(), 1);
      else                   chk("sum", bus.sum_out, exp_q.pop_front());
    end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rem(input int v);
    mem[wp[7:0]] = v;
    wp++;
  endtask

  task automatic put_local(input int v);
    for (int i = 0; i < 200 && bus.local_busy; i++) step(1);
    if (bus.local_busy) chk("local_wait_timeout", bus.local_busy, 0);
    bus.local_vld = 1;
    bus.local_sum = 24'(v);
    step(1);
    bus.local_vld = 0;
  endtask

  task automatic wait_xfers(input int n);
    for (int i = 0; i < 500 && xfers < n; i++) @(posedge clk);
    #1;
    if (xfers < n) chk("xfer_timeout", xfers, n);
  endtask

  task automatic wait_vld();
    for (int i = 0; i < 200 && !bus.sum_vld; i++) step(1);
    if (!bus.sum_vld) chk("vld_timeout", bus.sum_vld, 1);
  endtask

  task automatic run_pairs(input int n);
    int r [8];
    int l [8];
    for (int i = 0; i < n; i++) begin
      r[i] = int'($urandom_range(0, 4000000)) - 2000000;
      l[i] = int'($urandom_range(0, 4000000)) - 2000000;
      push_rem(r[i]);
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(sat24(l[i], r[i]));
      put_local(l[i]);
    end
  endtask

  task automatic clr_pulse();
    clr = 1;
    step(1);
    clr = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd"},   bus.fifo_rd, 0);
    chk({tag, "_vld"},  bus.sum_vld, 0);
    chk({tag, "_out"},  bus.sum_out, 0);
    chk({tag, "_busy"}, bus.local_busy, 0);
    chk({tag, "_pd"},   pass_done, 0);
    chk({tag, "_ovf"},  ovf, 0);
    chk({tag, "_err"},  err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int b, rd0;
    reset = 0; clr = 0;
    bus.local_vld = 0; bus.local_sum = '0; bus.sum_rdy = 0;
    push_rem(100);
    step(3);
    chk_idle("rst");

    // release: synchronizer holds off the first pop for two clocks
    reset = 1;
    step(1); chk("sync1_rd", bus.fifo_rd, 0);
    step(1); chk("sync2_rd", bus.fifo_rd, 0);

    // 100 + 23, held under backpressure
    exp_q.push_back(24'd123);
    put_local(23);
    wait_vld();
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("hold_vld", bus.sum_vld, 1);
      chk("hold_out", bus.sum_out, 123);
    end
    chk("one_pop", rd_cnt, 1);
    bus.sum_rdy = 1;
    wait_xfers(1);

    // positive and negative saturation, sticky ovf
    chk("ovf_pre", ovf, 0);
    push_rem(50);
    exp_q.push_back(sat24(8388598, 50));
    put_local(8388598);
    wait_xfers(2);
    chk("ovf_pos", ovf, 1);
    push_rem(-10);
    exp_q.push_back(sat24(-8388603, -10));
    put_local(-8388603);
    push_rem(2);
    exp_q.push_back(24'd5);
    put_local(3);
    wait_xfers(4);
    chk("ovf_sticky", ovf, 1);
    clr_pulse();
    chk_idle("clr");

    // full pass: pass_done one cycle after the 8th transfer, then no pops
    b = xfers;
    run_pairs(8);
    wait_xfers(b + 7); chk("pd_at7", pass_done, 0);
    wait_xfers(b + 8); chk("pd_at8", pass_done, 1);
    rd0 = rd_cnt;
    push_rem(1000); push_rem(2000); push_rem(3000);
    step(10);
    chk("no_pop_pd", rd_cnt, rd0);
    chk("pd_sticky", pass_done, 1);
    clr_pulse();
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(24'(1000 * i + i));
      put_local(i);
    end
    wait_xfers(b + 11);
    clr_pulse();

    // backpressure with a second pair pending
    b = xfers;
    bus.sum_rdy = 0;
    push_rem(10); push_rem(20);
    exp_q.push_back(24'd11); put_local(1);
    exp_q.push_back(24'd22); put_local(2);
    step(12);
    rd0 = rd_cnt;
    push_rem(30);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_out", bus.sum_out, 11);
      chk("bp_busy", bus.local_busy, 1);
    end
    chk("bp_no_pop", rd_cnt, rd0);
    bus.sum_rdy = 1;
    step(1);
    chk("bp_next_vld", bus.sum_vld, 1);
    chk("bp_next_out", bus.sum_out, 22);
    wait_xfers(b + 2);
    step(6);
    clr_pulse();

    // duplicate local word is dropped and flagged
    b = xfers;
    put_local(5);
    chk("err_busy", bus.local_busy, 1);
    bus.local_vld = 1; bus.local_sum = 24'd9;
    step(1);
    bus.local_vld = 0;
    chk("err_set", err, 1);
    push_rem(7);
    exp_q.push_back(24'd12);
    wait_xfers(b + 1);
    chk("err_sticky", err, 1);
    clr_pulse();

    // clr while the popped word is in flight: the word is lost
    push_rem(77);
    for (int i = 0; i < 50 && !bus.fifo_rd; i++) step(1);
    chk("cap_saw_pop", bus.fifo_rd, 1);
    step(1);
    clr_pulse();
    put_local(3);
    step(10);
    chk("cap_no_sum", bus.sum_vld, 0);
    chk("cap_busy", bus.local_busy, 1);
    clr_pulse();
    clr = 1; bus.local_vld = 1; bus.local_sum = 24'd99;
    step(1);
    clr = 0; bus.local_vld = 0;
    chk("clr_wins_busy", bus.local_busy, 0);
    chk("clr_wins_err", err, 0);

    // reset mid-pass after some transfers
    b = xfers;
    run_pairs(3);
    wait_xfers(b + 3);
    bus.sum_rdy = 0;
    push_rem(4);
    put_local(6);
    wait_vld();
    chk("pre_rst_out", bus.sum_out, 10);
    reset = 0;
    #1;
    chk_idle("midrst");
    step(2);
    reset = 1;
    step(3);
    bus.sum_rdy = 1;
    b = xfers;
    run_pairs(8);
    wait_xfers(b + 7); chk("rst_pd_at7", pass_done, 0);
    wait_xfers(b + 8); chk("rst_pd_at8", pass_done, 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/psum_rx.md
PSUM_RX -- requirements
Module: psum_rx

Interface
REQ-001 Parameter: BW_PSUM, default 20, per-column psum width; SW = BW_PSUM+4 = 24 is the exchanged sum width.
REQ-002 Parameter: ROWS, default 8, number of combined sums per normalization pass.
REQ-003 Port: clk  input  1  single clock, rising edge (read-side clock of the incoming async FIFO).
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: clr  input  1  synchronous pass clear, active-high.
REQ-006 Port: fifo_empty  input  1  empty flag of incoming async FIFO.
REQ-007 Port: fifo_rd  output  1  FIFO pop strobe.
REQ-008 Port: fifo_data  input  SW  FIFO read data; valid the cycle after fifo_rd.
REQ-009 Port: local_vld  input  1  local core sum strobe.
REQ-010 Port: local_sum  input  SW  local core sum, signed.
REQ-011 Port: local_busy  output  1  local slot occupied; core holds local_vld low while high.
REQ-012 Port: sum_vld  output  1  combined sum valid.
REQ-013 Port: sum_out  output  SW  combined sum, signed.
REQ-014 Port: sum_rdy  input  1  consumer accept; transfer when sum_vld and sum_rdy.
REQ-015 Port: pass_done  output  1  ROWS sums delivered, sticky until clr.
REQ-016 Port: ovf  output  1  sticky saturation flag.
REQ-017 Port: err  output  1  sticky flag: local_vld received while local_busy.

Function
REQ-018 Remote fetch FSM states R_IDLE, R_POP, R_CAP, R_FULL are used.
REQ-019 R_IDLE -> R_POP when fifo_empty=0 and pass_done=0; otherwise the FSM stays in R_IDLE.
REQ-020 In R_POP, fifo_rd=1 for exactly one cycle, then the FSM goes to R_CAP.
REQ-021 In R_CAP, fifo_data is latched into the remote slot and the FSM goes to R_FULL.
REQ-022 R_FULL -> R_IDLE in the cycle the remote slot is consumed by a combine.
REQ-023 fifo_rd is never high outside R_POP; at most one pop is outstanding.
REQ-024 local_vld with local_busy=0 latches local_sum, and local_busy=1 on the next cycle.
REQ-025 local_vld with local_busy=1 drops the word, sets err, and leaves the slot unchanged.
REQ-026 A combine fires when both slots are full and the output register is empty or is being drained in the same cycle (full throughput).
REQ-027 A combine loads sum_out = sat(local + remote) and sets sum_vld the next cycle.
REQ-028 A combine empties both slots in the same cycle it fires.
REQ-029 Addition is SW+1-bit signed; results above 2^(SW-1)-1 or below -2^(SW-1) clamp to those limits and set ovf.
REQ-030 sum_out and sum_vld stay stable while sum_vld=1 and sum_rdy=0.
REQ-031 The row counter (0..ROWS-1) increments on each output transfer.
REQ-032 The ROWS-th transfer sets pass_done on the next cycle and wraps the counter to 0.
REQ-033 While pass_done=1, no new pop starts; slots already full still combine and drain.
REQ-034 clr, in every FSM state, returns R_IDLE, empties all slots and the output register, zeroes the counter, and clears pass_done, ovf and err.
REQ-035 If clr arrives in R_POP or R_CAP, the popped FIFO word is discarded.
REQ-036 If clr and local_vld arrive in the same cycle, clr wins and local_sum is dropped.

Reset
REQ-037 reset low asynchronously forces R_IDLE and empties all slots.
REQ-038 During reset: fifo_rd=0, sum_vld=0, sum_out=0, local_busy=0, pass_done=0, ovf=0, err=0, counter=0.
REQ-039 Reset release is synchronized with a 2-flop deassertion synchronizer; the first pop can occur 2 cycles after release at the earliest.

Structure
REQ-040 The shared package holds SW, ROWS default and the remote-FSM state enumeration.
REQ-041 Saturating addition is one sub-module, psum_sat_add: combinational, SW inputs, SW output and an overflow bit.
REQ-042 All other logic is flat within psum_rx.

Verification
REQ-043 Scenario: FIFO preloaded with 100, then local_vld with 23 -> fifo_rd one pulse, sum_out=123, sum_vld=1, held until sum_rdy.
REQ-044 Scenario: local 2^23-10 plus remote 50 -> sum_out=8388607, ovf=1 and sticky after later normal sums.
REQ-045 Scenario: 8 paired sums with sum_rdy=1 -> one sum per cycle after fill, pass_done=1 one cycle after 8th transfer, no fifo_rd afterwards despite fifo_empty=0.
REQ-046 Scenario: sum_rdy=0 for 5 cycles with a second pair pending -> sum_out unchanged, local_busy=1, no further fifo_rd, second sum appears the cycle after sum_rdy=1.
REQ-047 Scenario: local_vld twice with no remote data -> err=1, first value retained, later remote 7 with first local 5 gives 12.
REQ-048 Scenario: clr in R_CAP, and separately reset low mid-pass -> all outputs at reset values, counter 0, popped word not emitted.
